alu_add_sub_pipe: RTL

- Parametrised, pipelined successor to the combinational 32-bit ripple add/sub unit.
- Splits a WIDTH-bit add/subtract into NUM_SEG segments of SEG_W bits, one segment per pipeline stage, with the carry registered between stages.
- Supports ADD/SUB/ADC/SBB and produces carry, signed overflow, zero and negative flags.
- Uses a valid/ready handshake so it sits between the issue logic and the writeback path of a multi-cycle execute unit.

---
 rtl/alu_add_sub_pipe.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/alu_add_sub_pipe.sv
// Pipelined add/subtract unit: WIDTH bits split into NUM_SEG segments of SEG_W bits,
// one segment per stage, carry registered between stages, valid/ready flow control.
module alu_add_sub_pipe #(
  parameter int WIDTH = 32,
  parameter int SEG_W = 8,
  parameter int TAG_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry,
  output logic             o_overflow,
  output logic             o_zero,
  output logic             o_negative,
  output logic [TAG_W-1:0] o_tag
);

  localparam int NUM_SEG = WIDTH / SEG_W;

  logic             advance_s;
  logic [WIDTH-1:0] b_eff_s;
  logic             c0_s;

  // Per-stage inputs: index 0 is the prepared operation, index k is stage k-1's register.
  logic             vin_s [NUM_SEG];
  logic [WIDTH-1:0] ain_s [NUM_SEG];
  logic [WIDTH-1:0] bin_s [NUM_SEG];
  logic [WIDTH-1:0] rin_s [NUM_SEG];
  logic             cin_s [NUM_SEG];
  logic             zin_s [NUM_SEG];
  logic [TAG_W-1:0] tin_s [NUM_SEG];

  assign advance_s = !o_valid || i_ready;
  assign o_ready   = advance_s;

  // Operand preparation: subtraction is a + ~b + 1, the carry-in modes take i_cin.
  always_comb begin
    b_eff_s = i_b;
    c0_s    = 1'b0;
    case (i_op)
      2'b00: begin b_eff_s = i_b;  c0_s = 1'b0;  end
      2'b01: begin b_eff_s = ~i_b; c0_s = 1'b1;  end
      2'b10: begin b_eff_s = i_b;  c0_s = i_cin; end
      2'b11: begin b_eff_s = ~i_b; c0_s = i_cin; end
      default: begin b_eff_s = i_b; c0_s = 1'b0; end
    endcase
  end

  assign vin_s[0] = i_valid;
  assign ain_s[0] = i_a;
  assign bin_s[0] = b_eff_s;
  assign rin_s[0] = {WIDTH{1'b0}};
  assign cin_s[0] = c0_s;
  assign zin_s[0] = 1'b1;
  assign tin_s[0] = i_tag;

  for (genvar k = 0; k < NUM_SEG; k++) begin : g_stage
    logic [SEG_W:0]   sum_s;
    logic [WIDTH-1:0] res_s;
    logic             zero_s;

    // Operands are shifted down so the active segment is always the lowest one;
    // finished result segments enter from the top so they line up after the last stage.
    assign sum_s  = {1'b0, ain_s[k][SEG_W-1:0]} + {1'b0, bin_s[k][SEG_W-1:0]}
                  + {{SEG_W{1'b0}}, cin_s[k]};
    assign res_s  = WIDTH'({sum_s[SEG_W-1:0], rin_s[k]} >> SEG_W);
    assign zero_s = zin_s[k] && (sum_s[SEG_W-1:0] == {SEG_W{1'b0}});

    if (k < NUM_SEG - 1) begin : g_mid
      logic             v_r;
      logic [WIDTH-1:0] a_r;
      logic [WIDTH-1:0] b_r;
      logic [WIDTH-1:0] r_r;
      logic             c_r;
      logic             z_r;
      logic [TAG_W-1:0] t_r;

      // Intermediate stage register; shifts only when the pipe advances.
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          v_r <= 1'b0;
          a_r <= {WIDTH{1'b0}};
          b_r <= {WIDTH{1'b0}};
          r_r <= {WIDTH{1'b0}};
          c_r <= 1'b0;
          z_r <= 1'b0;
          t_r <= {TAG_W{1'b0}};
        end else if (advance_s) begin
          v_r <= vin_s[k];
          a_r <= ain_s[k] >> SEG_W;
          b_r <= bin_s[k] >> SEG_W;
          r_r <= res_s;
          c_r <= sum_s[SEG_W];
          z_r <= zero_s;
          t_r <= tin_s[k];
        end
      end

      assign vin_s[k+1] = v_r;
      assign ain_s[k+1] = a_r;
      assign bin_s[k+1] = b_r;
      assign rin_s[k+1] = r_r;
      assign cin_s[k+1] = c_r;
      assign zin_s[k+1] = z_r;
      assign tin_s[k+1] = t_r;
    end else begin : g_last
      logic msb_c_s;

      // Carry into the MSB recovered from the top bit's operands and sum.
      assign msb_c_s = ain_s[k][SEG_W-1] ^ bin_s[k][SEG_W-1] ^ sum_s[SEG_W-1];

      // Output register; result and flags only change when a real op arrives.
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          o_valid    <= 1'b0;
          o_result   <= {WIDTH{1'b0}};
          o_carry    <= 1'b0;
          o_overflow <= 1'b0;
          o_zero     <= 1'b0;
          o_negative <= 1'b0;
          o_tag      <= {TAG_W{1'b0}};
        end else if (advance_s) begin
          o_valid <= vin_s[k];
          if (vin_s[k]) begin
            o_result   <= res_s;
            o_carry    <= sum_s[SEG_W];
            o_overflow <= msb_c_s ^ sum_s[SEG_W];
            o_zero     <= zero_s;
            o_negative <= sum_s[SEG_W-1];
            o_tag      <= tin_s[k];
          end
        end
      end
    end
  end

endmodule
